// File: rtl/pump_pwm_gen_if.sv
// Command/status bundle between the filter FSM side and the two-channel pump PWM generator.
interface pump_pwm_gen_if;
  logic [7:0] pwm_duty_a;
  logic [7:0] pwm_duty_b;
  logic       pwm_a;
  logic       pwm_b;
  logic [7:0] duty_act_a;
  logic [7:0] duty_act_b;
  logic       ramp_busy_a;
  logic       ramp_busy_b;
  logic       period_start;

  modport master (
    output pwm_duty_a, pwm_duty_b,
    input  pwm_a, pwm_b, duty_act_a, duty_act_b,
    input  ramp_busy_a, ramp_busy_b, period_start
  );

  modport slave (
    input  pwm_duty_a, pwm_duty_b,
    output pwm_a, pwm_b, duty_act_a, duty_act_b,
    output ramp_busy_a, ramp_busy_b, period_start
  );
endinterface

// File: rtl/pump_pwm_gen.sv
// Two-channel pump PWM: shared prescaler/period/ramp timebase, per-channel slew-limited duty
// with immediate stop on a zero command.
module pump_pwm_gen #(
  parameter int CLK_DIV      = 196,
  parameter int RAMP_PERIODS = 4,
  parameter int RAMP_STEP    = 8
) (
  input  logic            clk,
  input  logic            reset,
  pump_pwm_gen_if.slave   bus
);

  localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RC_W  = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(CLK_DIV - 1);
  localparam logic [RC_W-1:0]  RAMP_MAX = RC_W'(RAMP_PERIODS - 1);
  localparam logic [7:0]       CNT_MAX  = 8'd254;
  localparam logic [8:0]       STEP9    = 9'(RAMP_STEP);
  localparam logic [7:0]       STEP8    = 8'(RAMP_STEP);

  logic [PRE_W-1:0] pre_reg;
  logic [7:0]       cnt_reg;
  logic [RC_W-1:0]  ramp_cnt_reg;
  logic             period_start_reg;
  logic             tick;
  logic             period_end;
  logic             step_en;

  assign tick       = (pre_reg == PRE_MAX);
  assign period_end = tick && (cnt_reg == CNT_MAX);
  assign step_en    = period_end && (ramp_cnt_reg == RAMP_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_reg          <= '0;
      cnt_reg          <= '0;
      ramp_cnt_reg     <= '0;
      period_start_reg <= 1'b0;
    end else begin
      pre_reg          <= tick ? '0 : pre_reg + 1'b1;
      period_start_reg <= period_end;
      if (tick)
        cnt_reg <= period_end ? 8'd0 : cnt_reg + 8'd1;
      if (period_end)
        ramp_cnt_reg <= (ramp_cnt_reg == RAMP_MAX) ? '0 : ramp_cnt_reg + 1'b1;
    end
  end

  assign bus.period_start = period_start_reg;

  logic [7:0] target       [2];
  logic [7:0] duty_act_reg [2];
  logic       pwm_reg      [2];
  logic       busy         [2];

  assign target[0] = bus.pwm_duty_a;
  assign target[1] = bus.pwm_duty_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [8:0] up_sum;
      logic [7:0] duty_next;

      // Sums are widened to 9 bits so a step near 255 saturates at the target instead of wrapping.
      always_comb begin
        duty_next = duty_act_reg[gi];
        up_sum    = {1'b0, duty_act_reg[gi]} + STEP9;
        if (duty_act_reg[gi] < target[gi]) begin
          duty_next = (up_sum >= {1'b0, target[gi]}) ? target[gi] : up_sum[7:0];
        end else if (duty_act_reg[gi] > target[gi]) begin
          if ({1'b0, duty_act_reg[gi]} < (STEP9 + {1'b0, target[gi]}))
            duty_next = target[gi];
          else
            duty_next = duty_act_reg[gi] - STEP8;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          duty_act_reg[gi] <= 8'd0;
          pwm_reg[gi]      <= 1'b0;
        end else begin
          if (target[gi] == 8'd0)
            duty_act_reg[gi] <= 8'd0;
          else if (step_en)
            duty_act_reg[gi] <= duty_next;
          // cnt never exceeds 254, so duty 255 keeps the pin high for the whole period.
          pwm_reg[gi] <= (cnt_reg < duty_act_reg[gi]) && (target[gi] != 8'd0);
        end
      end

      assign busy[gi] = (duty_act_reg[gi] != target[gi]);
    end
  endgenerate

  assign bus.pwm_a       = pwm_reg[0];
  assign bus.pwm_b       = pwm_reg[1];
  assign bus.duty_act_a  = duty_act_reg[0];
  assign bus.duty_act_b  = duty_act_reg[1];
  assign bus.ramp_busy_a = busy[0];
  assign bus.ramp_busy_b = busy[1];

endmodule

// File: tb/tb_pump_pwm_gen.sv
// Directed bench: a fast-ramp instance (1/1/100) for ramp, stop, full-on and reset cases,
// plus a slow instance (3/2/8) for prescaled period and multi-period ramp timing.
module tb_pump_pwm_gen;
  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   vectors = 0;
  int   errs    = 0;

  always #5 clk = ~clk;

  pump_pwm_gen_if if1 ();
  pump_pwm_gen_if if2 ();

  pump_pwm_gen #(.CLK_DIV(1), .RAMP_PERIODS(1), .RAMP_STEP(100)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  pump_pwm_gen #(.CLK_DIV(3), .RAMP_PERIODS(2), .RAMP_STEP(8)) dut2 (
    .clk(clk), .reset(reset2), .bus(if2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps1(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if1.period_start && n < 2000);
  endtask

  task automatic wait_ps2(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if2.period_start && n < 4000);
  endtask

  // Count high samples over one full period starting from a period_start cycle.
  task automatic run_period1(input string tag, output int ha, output int hb);
    ha = 0;
    hb = 0;
    for (int i = 0; i < 255; i++) begin
      @(negedge clk);
      if (if1.pwm_a) ha++;
      if (if1.pwm_b) hb++;
    end
    chk({tag, "_ps"}, int'(if1.period_start), 1);
  endtask

  task automatic run_period2(input string tag, output int ha);
    ha = 0;
    for (int i = 0; i < 765; i++) begin
      @(negedge clk);
      if (if2.pwm_a) ha++;
    end
    chk({tag, "_ps"}, int'(if2.period_start), 1);
  endtask

  function automatic int exp2(input int p);
    int d;
    d = 8 * (p / 2);
    return (d > 77) ? 77 : d;
  endfunction

  initial begin
    int n, ha, hb;
    reset  = 1'b1;
    reset2 = 1'b1;
    if1.pwm_duty_a = 8'd0;
    if1.pwm_duty_b = 8'd0;
    if2.pwm_duty_a = 8'd0;
    if2.pwm_duty_b = 8'd0;
    repeat (3) @(negedge clk);

    chk("rst_pwm_a", int'(if1.pwm_a), 0);
    chk("rst_pwm_b", int'(if1.pwm_b), 0);
    chk("rst_act_a", int'(if1.duty_act_a), 0);
    chk("rst_act_b", int'(if1.duty_act_b), 0);
    chk("rst_ps", int'(if1.period_start), 0);
    chk("rst_busy_a", int'(if1.ramp_busy_a), 0);
    $display("reset state checked");

    reset = 1'b0;
    wait_ps1(n);
    chk("first_ps_latency", n, 255);
    $display("first period_start after %0d cycles", n);

    // Ramp up both channels toward 230.
    if1.pwm_duty_a = 8'd230;
    if1.pwm_duty_b = 8'd230;
    #1;
    chk("busy_a_set", int'(if1.ramp_busy_a), 1);
    run_period1("up0", ha, hb);
    chk("up0_high_a", ha, 0);
    chk("up0_act_a", int'(if1.duty_act_a), 100);
    chk("up0_act_b", int'(if1.duty_act_b), 100);
    $display("ramp step 1: act_a=%0d act_b=%0d", if1.duty_act_a, if1.duty_act_b);
    run_period1("up1", ha, hb);
    chk("up1_high_a", ha, 100);
    chk("up1_act_a", int'(if1.duty_act_a), 200);
    chk("up1_busy_a", int'(if1.ramp_busy_a), 1);
    $display("ramp step 2: high_a=%0d act_a=%0d", ha, if1.duty_act_a);
    run_period1("up2", ha, hb);
    chk("up2_high_a", ha, 200);
    chk("up2_high_b", hb, 200);
    chk("up2_act_a", int'(if1.duty_act_a), 230);
    chk("up2_busy_a", int'(if1.ramp_busy_a), 0);
    chk("up2_busy_b", int'(if1.ramp_busy_b), 0);
    $display("ramp step 3: high_a=%0d act_a=%0d", ha, if1.duty_act_a);

    // Ramp B down to 77 while A holds.
    if1.pwm_duty_b = 8'd77;
    run_period1("dn0", ha, hb);
    chk("dn0_high_a", ha, 230);
    chk("dn0_high_b", hb, 230);
    chk("dn0_act_b", int'(if1.duty_act_b), 130);
    chk("dn0_busy_b", int'(if1.ramp_busy_b), 1);
    chk("dn0_act_a", int'(if1.duty_act_a), 230);
    $display("ramp down 1: act_b=%0d", if1.duty_act_b);
    run_period1("dn1", ha, hb);
    chk("dn1_high_b", hb, 130);
    chk("dn1_act_b", int'(if1.duty_act_b), 77);
    chk("dn1_busy_b", int'(if1.ramp_busy_b), 0);
    $display("ramp down 2: act_b=%0d", if1.duty_act_b);
    run_period1("dn2", ha, hb);
    chk("dn2_high_b", hb, 77);
    chk("dn2_high_a", ha, 230);
    $display("steady: high_a=%0d high_b=%0d", ha, hb);

    // Mid-period stop on A.
    repeat (100) @(negedge clk);
    chk("stop_pre_pwm_a", int'(if1.pwm_a), 1);
    if1.pwm_duty_a = 8'd0;
    @(negedge clk);
    chk("stop_pwm_a", int'(if1.pwm_a), 0);
    chk("stop_act_a", int'(if1.duty_act_a), 0);
    chk("stop_busy_a", int'(if1.ramp_busy_a), 0);
    $display("stop: pwm_a=%0d act_a=%0d", if1.pwm_a, if1.duty_act_a);
    wait_ps1(n);
    chk("stop_to_ps", n, 154);

    // Full-on A, off B.
    if1.pwm_duty_a = 8'd255;
    if1.pwm_duty_b = 8'd0;
    run_period1("full0", ha, hb);
    chk("full0_high_b", hb, 0);
    chk("full0_act_a", int'(if1.duty_act_a), 100);
    chk("full0_act_b", int'(if1.duty_act_b), 0);
    run_period1("full1", ha, hb);
    chk("full1_high_a", ha, 100);
    run_period1("full2", ha, hb);
    chk("full2_act_a", int'(if1.duty_act_a), 255);
    run_period1("full3", ha, hb);
    chk("full3_high_a", ha, 255);
    chk("full3_high_b", hb, 0);
    run_period1("full4", ha, hb);
    chk("full4_high_a", ha, 255);
    chk("full4_high_b", hb, 0);
    $display("full-on: high_a=%0d high_b=%0d", ha, hb);

    // Reset mid-period with A applied at 200.
    if1.pwm_duty_a = 8'd200;
    run_period1("r0", ha, hb);
    chk("r0_high_a", ha, 255);
    chk("r0_act_a", int'(if1.duty_act_a), 200);
    repeat (50) @(negedge clk);
    chk("r_pre_pwm_a", int'(if1.pwm_a), 1);
    #2 reset = 1'b1;
    #1;
    chk("r_async_pwm_a", int'(if1.pwm_a), 0);
    chk("r_async_act_a", int'(if1.duty_act_a), 0);
    chk("r_async_ps", int'(if1.period_start), 0);
    $display("async reset: pwm_a=%0d act_a=%0d", if1.pwm_a, if1.duty_act_a);
    @(negedge clk);
    reset = 1'b0;
    wait_ps1(n);
    chk("r_ps_latency", n, 255);
    chk("r_restart_act_a", int'(if1.duty_act_a), 100);
    $display("after reset: ps latency %0d act_a=%0d", n, if1.duty_act_a);

    // Prescaled instance: 765-cycle periods, +8 every 2 periods up to 77.
    if2.pwm_duty_a = 8'd77;
    reset2 = 1'b0;
    wait_ps2(n);
    chk("s_ps_latency", n, 765);
    for (int p = 1; p <= 20; p++) begin
      chk($sformatf("s%0d_act", p), int'(if2.duty_act_a), exp2(p));
      run_period2($sformatf("s%0d", p), ha);
      chk($sformatf("s%0d_high", p), ha, 3 * exp2(p));
      $display("slow period %0d: act=%0d high=%0d", p, exp2(p), ha);
    end
    chk("s_final_act", int'(if2.duty_act_a), 77);
    chk("s_final_busy", int'(if2.ramp_busy_a), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
